intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Parametrised interrupt controller replacing the fixed 4-bit inline interrupt logic in the top level.
//  Latches N synchronous interrupt strobes (Copper, blitter, video, timer, CPU force) into sticky status.
//  Applies the mask, reports the lowest pending ID and a sticky per-channel overflow flag.
//  Drives the CPU bus interrupt as a level or as a stretched pulse; sits between units and reg_interface.
// PARAMETERS
//  NUM_INTR      4   number of interrupt channels (1..16)
//  OUT_PULSE     1   1 = bus_intr_o is a pulse on each new masked-pending event; 0 = level while any masked pending
//  PULSE_CYCLES  1   bus_intr_o pulse width in clk cycles (1..255); ignored when OUT_PULSE=0
// PORTS
//  clk              in   1         pixel clock
//  reset_n_i        in   1         asynchronous active-low reset
//  intr_signal_i    in   NUM_INTR  one-cycle event strobes from units (1 = set status)
//  intr_force_i     in   NUM_INTR  CPU software-set strobe, treated identically to intr_signal_i
//  intr_clear_i     in   NUM_INTR  CPU write-1-to-clear strobe (status and overflow)
//  intr_mask_i      in   NUM_INTR  1 = channel enabled to interrupt CPU
//  intr_status_o    out  NUM_INTR  sticky pending status (unmasked view)
//  intr_overflow_o  out  NUM_INTR  sticky: event arrived while channel already pending
//  intr_pending_o   out  1         |(status & mask)
//  intr_id_o        out  4         lowest-index masked pending channel; 0 when none pending
//  bus_intr_o       out  1         CPU interrupt request, active high
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low: reset_n_i=0 immediately clears all state;
//    all outputs are 0 during and after reset until the first event. Reset mid-pulse aborts the pulse.
//  - set = intr_signal_i | intr_force_i. All outputs are registered or decoded from registers.
//  - status_next = (status & ~intr_clear_i) | set. Set wins over a same-cycle clear, so no event is lost.
//  - overflow_next = (overflow & ~intr_clear_i) | (set & status & ~intr_clear_i).
//    Set on an already-pending bit flags overflow; set together with clear does not.
//  - Latency: set at cycle T -> intr_status_o, intr_pending_o, intr_id_o valid at T+1.
//  - intr_pending_o and intr_id_o are combinational from the status register and intr_mask_i.
//    Mask changes take effect in the same cycle. intr_id_o uses a fixed-priority encoder, bit 0 highest.
//  - new_evt = |((set & ~status & intr_mask_i) | (intr_mask_i & ~mask_q & status)).
//    Covers a newly pending masked bit and the unmasking of an already-pending bit. mask_q is intr_mask_i delayed one cycle.
//  - OUT_PULSE=0: bus_intr_o <= |(status_next & intr_mask_i). It deasserts the cycle after the last pending bit clears or is masked.
//  - OUT_PULSE=1: FSM with states IDLE and PULSE; the counter is $clog2(PULSE_CYCLES+1) bits wide.
//    IDLE: on new_evt, bus_intr_o<=1, cnt<=PULSE_CYCLES-1, go to PULSE (or stay IDLE with a 1-cycle pulse if PULSE_CYCLES=1).
//    PULSE: a new_evt reloads cnt (retrigger extends the pulse). At cnt==0 with no new_evt, bus_intr_o<=0 and go to IDLE.
//    Otherwise cnt decrements. Clearing status does not shorten an active pulse.
//  - Events on masked channels still set status/overflow but never assert bus_intr_o.
//  - Unused upper bits of intr_id_o are 0 when NUM_INTR < 16.
// STRUCTURE
//  - xosera_pkg (xv): add INTR_NUM = 4 and typedef intr_t = logic [INTR_NUM-1:0]; top level instantiates with INTR_NUM.
//  - One sub-module, intr_prio_enc: parametrised lowest-set-bit encoder producing intr_id_o and the any-bit flag.
//  - Top level: connect intr_signal_i to video_gen/copper (and blitter when ENABLE_BLIT).
//    Connect mask/clear/force to reg_interface; intr_status_o feeds the VID_CTRL read-back.
// TESTING
//  1 Reset: assert reset_n_i asynchronously mid-pulse -> bus_intr_o, status, overflow, intr_id_o = 0 immediately.
//  2 NUM_INTR=4, PULSE_CYCLES=3, mask=4'b0101, signal=4'b0100 at T.
//    -> status=4'b0100 at T+1, intr_id_o=2, bus_intr_o high for T+1..T+3, then low.
//  3 Status=4'b0001, signal=4'b0001 and clear=4'b0001 in the same cycle -> status stays 4'b0001, overflow stays 0.
//    Signal again next cycle without clear -> overflow=4'b0001.
//  4 Mask=0, signal=4'b1000 -> status=4'b1000, bus_intr_o stays 0.
//    Then mask=4'b1000 -> pulse starts the next cycle, intr_id_o=3.
//  5 OUT_PULSE=0, mask=4'b0011, signal=4'b0011 -> bus_intr_o high, intr_id_o=0.
//    Clear 4'b0001 -> intr_id_o=1, bus_intr_o still high; clear 4'b0010 -> bus_intr_o low the next cycle.
//  6 PULSE_CYCLES=4: second new event 2 cycles into the pulse -> bus_intr_o stays high 4 cycles after the retrigger (6 total).

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared types for the interrupt controller: channel vector type and the
// bus-interrupt pulse FSM state encoding.
package intr_ctrl_pkg;
  localparam int INTR_NUM = 4;
  typedef logic [INTR_NUM-1:0] intr_t;
  typedef enum logic {ST_IDLE, ST_PULSE} pulse_st_e;
endpackage

// File: rtl/intr_ctrl_if.sv
// Interrupt bundle between event sources / CPU register block (master)
// and the interrupt controller (slave).
interface intr_ctrl_if #(parameter int NUM_INTR = 4);
  logic [NUM_INTR-1:0] intr_signal_i;
  logic [NUM_INTR-1:0] intr_force_i;
  logic [NUM_INTR-1:0] intr_clear_i;
  logic [NUM_INTR-1:0] intr_mask_i;
  logic [NUM_INTR-1:0] intr_status_o;
  logic [NUM_INTR-1:0] intr_overflow_o;
  logic                intr_pending_o;
  logic [3:0]          intr_id_o;
  logic                bus_intr_o;

  modport master (
    output intr_signal_i, intr_force_i, intr_clear_i, intr_mask_i,
    input  intr_status_o, intr_overflow_o, intr_pending_o, intr_id_o, bus_intr_o
  );
  modport slave (
    input  intr_signal_i, intr_force_i, intr_clear_i, intr_mask_i,
    output intr_status_o, intr_overflow_o, intr_pending_o, intr_id_o, bus_intr_o
  );
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit (bit 0 wins), plus an
// any-set flag. Upper id bits stay 0 for narrow vectors.
module intr_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [3:0]   id,
  output logic         any
);
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) id = 4'(i);
  end

  assign any = |vec;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: sticky status/overflow per channel, masked pending
// decode, and a CPU interrupt driven as a level or a retriggerable pulse.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_INTR     = INTR_NUM,
  parameter bit OUT_PULSE    = 1'b1,
  parameter int PULSE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  intr_ctrl_if.slave  bus
);
  logic [NUM_INTR-1:0] set, status_q, status_nx, ovf_q, ovf_nx, mask_q;
  logic                new_evt, bus_q;

  assign set       = bus.intr_signal_i | bus.intr_force_i;
  // Set beats a same-cycle clear; overflow only counts uncleared re-hits.
  assign status_nx = (status_q & ~bus.intr_clear_i) | set;
  assign ovf_nx    = (ovf_q & ~bus.intr_clear_i) | (set & status_q & ~bus.intr_clear_i);
  assign new_evt   = |((set & ~status_q & bus.intr_mask_i) |
                       (bus.intr_mask_i & ~mask_q & status_q));

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      status_q <= '0;
      ovf_q    <= '0;
      mask_q   <= '0;
    end else begin
      status_q <= status_nx;
      ovf_q    <= ovf_nx;
      mask_q   <= bus.intr_mask_i;
    end
  end

  intr_prio_enc #(.N(NUM_INTR)) u_enc (
    .vec (status_q & bus.intr_mask_i),
    .id  (bus.intr_id_o),
    .any (bus.intr_pending_o)
  );

  generate
    if (OUT_PULSE) begin : g_pulse
      localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
      localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_CYCLES - 1);
      pulse_st_e        state_q, state_nx;
      logic [CNT_W-1:0] cnt_q, cnt_nx;
      logic             bus_nx;

      always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          bus_q   <= 1'b0;
        end else begin
          state_q <= state_nx;
          cnt_q   <= cnt_nx;
          bus_q   <= bus_nx;
        end
      end

      // Single-cycle pulses never leave IDLE.
      always_comb begin
        state_nx = state_q;
        case (state_q)
          ST_IDLE:  if (new_evt && PULSE_CYCLES > 1) state_nx = ST_PULSE;
          ST_PULSE: if (!new_evt && cnt_q == '0)     state_nx = ST_IDLE;
          default:  state_nx = ST_IDLE;
        endcase
      end

      always_comb begin
        cnt_nx = cnt_q;
        bus_nx = bus_q;
        case (state_q)
          ST_IDLE: begin
            bus_nx = new_evt;
            if (new_evt) cnt_nx = RELOAD;
          end
          ST_PULSE: begin
            if (new_evt) begin
              cnt_nx = RELOAD;
              bus_nx = 1'b1;
            end else if (cnt_q == '0) begin
              bus_nx = 1'b0;
            end else begin
              cnt_nx = cnt_q - CNT_W'(1);
            end
          end
          default: bus_nx = 1'b0;
        endcase
      end
    end else begin : g_level
      always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) bus_q <= 1'b0;
        else            bus_q <= |(status_nx & bus.intr_mask_i);
      end
    end
  endgenerate

  assign bus.intr_status_o   = status_q;
  assign bus.intr_overflow_o = ovf_q;
  assign bus.bus_intr_o      = bus_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench: three controller flavours (pulse x3, pulse x4, level)
// share one stimulus stream; a reference model queues expected outputs.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  localparam int ND = 3;
  localparam int PCS [ND] = '{3, 4, 1};
  localparam bit PLS [ND] = '{1'b1, 1'b1, 1'b0};

  logic clk, reset_n;
  logic [3:0] sig, frc, clr, msk;

  intr_ctrl_if #(.NUM_INTR(4)) if0 ();
  intr_ctrl_if #(.NUM_INTR(4)) if1 ();
  intr_ctrl_if #(.NUM_INTR(4)) if2 ();

  assign if0.intr_signal_i = sig; assign if0.intr_force_i = frc;
  assign if0.intr_clear_i  = clr; assign if0.intr_mask_i  = msk;
  assign if1.intr_signal_i = sig; assign if1.intr_force_i = frc;
  assign if1.intr_clear_i  = clr; assign if1.intr_mask_i  = msk;
  assign if2.intr_signal_i = sig; assign if2.intr_force_i = frc;
  assign if2.intr_clear_i  = clr; assign if2.intr_mask_i  = msk;

  intr_ctrl #(.NUM_INTR(4), .OUT_PULSE(1'b1), .PULSE_CYCLES(3)) dut0 (.clk(clk), .reset_n_i(reset_n), .bus(if0));
  intr_ctrl #(.NUM_INTR(4), .OUT_PULSE(1'b1), .PULSE_CYCLES(4)) dut1 (.clk(clk), .reset_n_i(reset_n), .bus(if1));
  intr_ctrl #(.NUM_INTR(4), .OUT_PULSE(1'b0), .PULSE_CYCLES(1)) dut2 (.clk(clk), .reset_n_i(reset_n), .bus(if2));

  logic [ND-1:0][3:0] act_st, act_ov, act_id;
  logic [ND-1:0]      act_pend, act_bus;
  assign act_st   = {if2.intr_status_o,   if1.intr_status_o,   if0.intr_status_o};
  assign act_ov   = {if2.intr_overflow_o, if1.intr_overflow_o, if0.intr_overflow_o};
  assign act_id   = {if2.intr_id_o,       if1.intr_id_o,       if0.intr_id_o};
  assign act_pend = {if2.intr_pending_o,  if1.intr_pending_o,  if0.intr_pending_o};
  assign act_bus  = {if2.bus_intr_o,      if1.bus_intr_o,      if0.bus_intr_o};

  typedef struct {
    logic [ND-1:0][3:0] st, ov, id;
    logic [ND-1:0]      pend, bus;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;

  // Reference model state, one slot per DUT flavour.
  logic [3:0] m_st [ND], m_ov [ND], m_mp [ND];
  int         m_rem [ND];
  logic       m_lvl [ND];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int d, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, d, $time, act, req);
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int b = 0; b < 4; b++) if (v[b]) return 4'(b);
    return 4'd0;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int d = 0; d < ND; d++) begin
        chk("status",   d, int'(act_st[d]),   int'(e.st[d]));
        chk("overflow", d, int'(act_ov[d]),   int'(e.ov[d]));
        chk("pending",  d, int'(act_pend[d]), int'(e.pend[d]));
        chk("id",       d, int'(act_id[d]),   int'(e.id[d]));
        chk("bus_intr", d, int'(act_bus[d]),  int'(e.bus[d]));
      end
    end
  end

  // Drive one cycle's inputs, queue what must be visible this cycle, then
  // advance the model across the coming clock edge.
  task automatic do_cycle(input logic [3:0] s, f, c, m, input bit r);
    exp_t e;
    logic [3:0] set;
    bit newly;
    @(posedge clk); #1;
    sig = s; frc = f; clr = c; msk = m; reset_n = !r;
    set = s | f;
    for (int d = 0; d < ND; d++) begin
      if (r) begin
        m_st[d] = '0; m_ov[d] = '0; m_mp[d] = '0; m_rem[d] = 0; m_lvl[d] = 1'b0;
      end
      e.st[d]   = m_st[d];
      e.ov[d]   = m_ov[d];
      e.pend[d] = |(m_st[d] & m);
      e.id[d]   = lowest(m_st[d] & m);
      e.bus[d]  = PLS[d] ? (m_rem[d] > 0) : m_lvl[d];
      if (!r) begin
        newly = 1'b0;
        for (int b = 0; b < 4; b++) begin
          if (m[b] && ((set[b] && !m_st[d][b]) || (!m_mp[d][b] && m_st[d][b]))) newly = 1'b1;
          m_ov[d][b] = !c[b] && (m_ov[d][b] || (set[b] && m_st[d][b]));
          m_st[d][b] = set[b] || (m_st[d][b] && !c[b]);
        end
        m_rem[d] = newly ? PCS[d] : (m_rem[d] > 0 ? m_rem[d] - 1 : 0);
        m_lvl[d] = |(m_st[d] & m);
        m_mp[d]  = m;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] m);
    repeat (n) do_cycle(4'h0, 4'h0, 4'h0, m, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; sig = '0; frc = '0; clr = '0; msk = '0;
    do_cycle(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    do_cycle(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(2, 4'h0);
    // Masked event on channel 2, pulse width 3 / 4 / level.
    do_cycle(4'b0100, 4'h0, 4'h0, 4'b0101, 1'b0);
    idle(6, 4'b0101);
    // Set+clear same cycle keeps status, no overflow; plain re-hit overflows.
    do_cycle(4'h0, 4'h0, 4'hF, 4'b0101, 1'b0);
    do_cycle(4'b0001, 4'h0, 4'h0, 4'b0101, 1'b0);
    do_cycle(4'b0001, 4'h0, 4'b0001, 4'b0101, 1'b0);
    do_cycle(4'b0001, 4'h0, 4'h0, 4'b0101, 1'b0);
    idle(5, 4'b0101);
    // Event on masked channel, later unmasked.
    do_cycle(4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    do_cycle(4'b1000, 4'h0, 4'h0, 4'h0, 1'b0);
    idle(3, 4'h0);
    idle(6, 4'b1000);
    // Two channels pending, cleared one at a time.
    do_cycle(4'h0, 4'h0, 4'hF, 4'b0011, 1'b0);
    do_cycle(4'b0011, 4'h0, 4'h0, 4'b0011, 1'b0);
    idle(2, 4'b0011);
    do_cycle(4'h0, 4'h0, 4'b0001, 4'b0011, 1'b0);
    idle(1, 4'b0011);
    do_cycle(4'h0, 4'h0, 4'b0010, 4'b0011, 1'b0);
    idle(2, 4'b0011);
    // Retrigger via force two cycles into a pulse.
    do_cycle(4'h0, 4'h0, 4'hF, 4'hF, 1'b0);
    do_cycle(4'b0001, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(1, 4'hF);
    do_cycle(4'h0, 4'b0010, 4'h0, 4'hF, 1'b0);
    idle(8, 4'hF);
    // Asynchronous reset in the middle of a pulse.
    do_cycle(4'h0, 4'h0, 4'hF, 4'b0101, 1'b0);
    do_cycle(4'b0100, 4'h0, 4'h0, 4'b0101, 1'b0);
    idle(1, 4'b0101);
    do_cycle(4'h0, 4'h0, 4'h0, 4'b0101, 1'b1);
    do_cycle(4'h0, 4'h0, 4'h0, 4'b0101, 1'b1);
    idle(3, 4'b0101);
    // Random traffic with sparse strobes, occasional mask changes.
    begin
      logic [3:0] rm;
      rm = 4'($urandom);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 15) == 0) rm = 4'($urandom);
        do_cycle(4'($urandom & $urandom), 4'($urandom & $urandom & $urandom),
                 4'($urandom & $urandom), rm, $urandom_range(0, 199) == 0);
      end
    end
    idle(2, 4'h0);
    @(posedge clk); @(posedge clk);
    chk("drain", 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
